// File: rtl/cve2_xif_mac_copro.sv
// CV-X-IF multiply-accumulate coprocessor for the custom-0 opcode (7'h0B).
// Define CVE2_XIF_COPRO_FASTMUL_EN for a single-cycle multiplier; default is 32-cycle shift-add.
module cve2_xif_mac_copro (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        xif_issue_valid_i,
   input  logic [31:0] xif_issue_req_instr_i,
   output logic        xif_issue_ready_o,
   output logic        xif_issue_resp_accept_o,
   output logic        xif_issue_resp_writeback_o,
   output logic [2:0]  xif_issue_resp_register_read_o,
   input  logic [31:0] xif_register_rs1_i,
   input  logic [31:0] xif_register_rs2_i,
   input  logic [31:0] xif_register_rs3_i,
   input  logic [2:0]  xif_register_rs_valid_i,
   input  logic        xif_commit_valid_i,
   input  logic        xif_commit_kill_i,
   input  logic        xif_result_ready_i,
   output logic        xif_result_valid_o,
   output logic        xif_result_we_o,
   output logic [31:0] xif_result_data_o
);

   localparam logic [6:0] OPCODE = 7'h0B;
   localparam logic [1:0] F_MAC  = 2'd0;
   localparam logic [1:0] F_CLR  = 2'd1;
   localparam logic [1:0] F_RD   = 2'd2;
   localparam logic [1:0] F_MADD = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_EXEC   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_live;
   logic [1:0]  r_op;
   logic [31:0] r_acc;
   logic [31:0] r_mcand;
   logic [31:0] r_mplier;
   logic [31:0] r_prod;
   logic        r_result_valid;
   logic        r_result_we;
   logic [31:0] r_result_data;
   logic        w_accept;
   logic        w_wb;
   logic [2:0]  w_reads;
   logic        w_issue_hs;
   logic        w_done;
   logic [31:0] w_sum;
   logic        w_unused;

   assign w_unused = ^{xif_issue_req_instr_i[31:15], xif_issue_req_instr_i[11:7]};

   always_comb begin
      w_accept = 1'b0;
      w_wb     = 1'b0;
      w_reads  = 3'b000;
      if (xif_issue_req_instr_i[6:0] == OPCODE) begin
         case (xif_issue_req_instr_i[14:12])
            3'b000: begin w_accept = 1'b1; w_wb = 1'b1; w_reads = 3'b011; end
            3'b001: begin w_accept = 1'b1; w_wb = 1'b0; w_reads = 3'b000; end
            3'b010: begin w_accept = 1'b1; w_wb = 1'b1; w_reads = 3'b000; end
            3'b011: begin w_accept = 1'b1; w_wb = 1'b1; w_reads = 3'b111; end
            default: begin w_accept = 1'b0; w_wb = 1'b0; w_reads = 3'b000; end
         endcase
      end else begin
         w_accept = 1'b0;
         w_wb     = 1'b0;
         w_reads  = 3'b000;
      end
   end

   // r_live keeps ready low while in reset and for the first cycle after release
   assign xif_issue_ready_o = (r_state == S_IDLE) & r_live &
                              ((xif_register_rs_valid_i & w_reads) == w_reads);
   assign xif_issue_resp_accept_o        = w_accept;
   assign xif_issue_resp_writeback_o     = w_wb;
   assign xif_issue_resp_register_read_o = w_reads;
   assign w_issue_hs = xif_issue_valid_i & xif_issue_ready_o;

`ifdef CVE2_XIF_COPRO_FASTMUL_EN
   assign w_done = 1'b1;
   assign w_sum  = r_prod + r_mcand * r_mplier;
`else
   logic [4:0] r_cnt;
   assign w_done = (r_op == F_CLR) | (r_op == F_RD) | (r_cnt == 5'd31);
   assign w_sum  = r_prod + (r_mplier[0] ? r_mcand : 32'd0);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_issue_hs & w_accept) begin
               if (xif_commit_valid_i) begin
                  w_state_nxt = xif_commit_kill_i ? S_IDLE : S_EXEC;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (xif_commit_valid_i) begin
               w_state_nxt = xif_commit_kill_i ? S_IDLE : S_EXEC;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_EXEC: begin
            if (w_done) begin
               w_state_nxt = S_RESULT;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_RESULT: begin
            if (xif_result_ready_i) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RESULT;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The addend (acc for MAC, rs3 for MADD) seeds the product register at issue
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_op           <= 2'd0;
         r_acc          <= 32'd0;
         r_mcand        <= 32'd0;
         r_mplier       <= 32'd0;
         r_prod         <= 32'd0;
         r_result_valid <= 1'b0;
         r_result_we    <= 1'b0;
         r_result_data  <= 32'd0;
`ifndef CVE2_XIF_COPRO_FASTMUL_EN
         r_cnt          <= 5'd0;
`endif
      end else if (r_state == S_IDLE) begin
         if (w_issue_hs & w_accept) begin
            r_op     <= xif_issue_req_instr_i[13:12];
            r_mcand  <= xif_register_rs1_i;
            r_mplier <= xif_register_rs2_i;
            r_prod   <= (xif_issue_req_instr_i[13:12] == F_MADD) ? xif_register_rs3_i : r_acc;
`ifndef CVE2_XIF_COPRO_FASTMUL_EN
            r_cnt    <= 5'd0;
`endif
         end
      end else if (r_state == S_EXEC) begin
         if (w_done) begin
            r_result_valid <= 1'b1;
            case (r_op)
               F_MAC:   begin r_acc <= w_sum; r_result_data <= w_sum; r_result_we <= 1'b1; end
               F_CLR:   begin r_acc <= 32'd0; r_result_data <= 32'd0; r_result_we <= 1'b0; end
               F_RD:    begin r_result_data <= r_acc; r_result_we <= 1'b1; end
               F_MADD:  begin r_result_data <= w_sum; r_result_we <= 1'b1; end
               default: begin r_result_data <= 32'd0; r_result_we <= 1'b0; end
            endcase
         end else begin
`ifndef CVE2_XIF_COPRO_FASTMUL_EN
            r_prod   <= w_sum;
            r_mcand  <= {r_mcand[30:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_cnt    <= r_cnt + 5'd1;
`endif
         end
      end else if (r_state == S_RESULT) begin
         if (xif_result_ready_i) begin
            r_result_valid <= 1'b0;
            r_result_we    <= 1'b0;
            r_result_data  <= 32'd0;
         end
      end
   end

   assign xif_result_valid_o = r_result_valid;
   assign xif_result_we_o    = r_result_we;
   assign xif_result_data_o  = r_result_data;

endmodule

// File: tb/tb_cve2_xif_mac_copro.sv
// Self-checking bench for cve2_xif_mac_copro: random operations checked against an accumulator model.
`timescale 1ns/1ps
module tb_cve2_xif_mac_copro;

`ifdef CVE2_XIF_COPRO_FASTMUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        issue_valid;
   logic [31:0] instr;
   logic        issue_ready;
   logic        accept;
   logic        wb;
   logic [2:0]  reads;
   logic [31:0] rs1, rs2, rs3;
   logic [2:0]  rs_valid;
   logic        commit_valid;
   logic        commit_kill;
   logic        result_ready;
   logic        result_valid;
   logic        result_we;
   logic [31:0] result_data;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] acc_m = 32'd0;

   always #5 clk = ~clk;

   cve2_xif_mac_copro dut (
      .clk_i                          (clk),
      .rst_ni                         (rst_ni),
      .xif_issue_valid_i              (issue_valid),
      .xif_issue_req_instr_i          (instr),
      .xif_issue_ready_o              (issue_ready),
      .xif_issue_resp_accept_o        (accept),
      .xif_issue_resp_writeback_o     (wb),
      .xif_issue_resp_register_read_o (reads),
      .xif_register_rs1_i             (rs1),
      .xif_register_rs2_i             (rs2),
      .xif_register_rs3_i             (rs3),
      .xif_register_rs_valid_i        (rs_valid),
      .xif_commit_valid_i             (commit_valid),
      .xif_commit_kill_i              (commit_kill),
      .xif_result_ready_i             (result_ready),
      .xif_result_valid_o             (result_valid),
      .xif_result_we_o                (result_we),
      .xif_result_data_o              (result_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc(input logic [2:0] f3);
      return {17'd0, f3, 5'd7, 7'h0B};
   endfunction

   // Issue one op, commit after cdel cycles (or kill), then check the result against the model
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int cdel, input logic kill, input int hold);
      int          lat;
      int          guard;
      int          explat;
      logic [31:0] exp_d;
      logic        exp_we;
      logic [2:0]  exp_rd;
      logic        seen;
      issue_valid = 1'b0;
      rs_valid    = 3'b111;
      guard = 0;
      while (issue_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
      checks++;
      if (issue_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: got %b exp 1", issue_ready); end
      case (f3)
         3'd0:    begin exp_d = acc_m + a * b; exp_we = 1'b1; exp_rd = 3'b011; explat = MUL_LAT; end
         3'd1:    begin exp_d = 32'd0;         exp_we = 1'b0; exp_rd = 3'b000; explat = 2; end
         3'd2:    begin exp_d = acc_m;         exp_we = 1'b1; exp_rd = 3'b000; explat = 2; end
         default: begin exp_d = a * b + c;     exp_we = 1'b1; exp_rd = 3'b111; explat = MUL_LAT; end
      endcase
      explat += cdel;
      instr = enc(f3); rs1 = a; rs2 = b; rs3 = c;
      issue_valid  = 1'b1;
      commit_valid = (cdel == 0);
      commit_kill  = kill;
      #1;
      checks++;
      if (accept !== 1'b1 || wb !== exp_we || reads !== exp_rd) begin
         errors++;
         $display("FAIL issue_resp f3=%0d: got acc=%b wb=%b rd=%b exp 1 %b %b", f3, accept, wb, reads, exp_we, exp_rd);
      end
      tick();
      issue_valid = 1'b0; commit_valid = 1'b0;
      lat = 1;
      if (cdel > 0) begin
         repeat (cdel - 1) begin tick(); lat++; end
         commit_valid = 1'b1;
         tick(); lat++;
         commit_valid = 1'b0;
      end
      commit_kill = 1'b0;
      if (kill) begin
         seen = 1'b0;
         repeat (40) begin tick(); if (result_valid === 1'b1) seen = 1'b1; end
         checks++;
         if (seen !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill: got result_seen=%b ready=%b exp 0 1", seen, issue_ready);
         end
      end else begin
         while (result_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
         checks++;
         if (lat !== explat) begin errors++; $display("FAIL latency f3=%0d: got %0d exp %0d", f3, lat, explat); end
         checks++;
         if (result_data !== exp_d || result_we !== exp_we) begin
            errors++;
            $display("FAIL result f3=%0d: got data=%h we=%b exp %h %b", f3, result_data, result_we, exp_d, exp_we);
         end
         repeat (hold) begin
            tick();
            checks++;
            if (result_valid !== 1'b1 || result_data !== exp_d || issue_ready !== 1'b0) begin
               errors++;
               $display("FAIL backpressure: got v=%b d=%h rdy=%b exp 1 %h 0", result_valid, result_data, issue_ready, exp_d);
            end
         end
         result_ready = 1'b1;
         tick();
         checks++;
         if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL result_done: got v=%b rdy=%b exp 0 1", result_valid, issue_ready);
         end
         if (f3 == 3'd0) acc_m = exp_d;
         else if (f3 == 3'd1) acc_m = 32'd0;
      end
   endtask

   task automatic test_reset();
      checks++;
      if (result_valid !== 1'b0 || result_we !== 1'b0 || result_data !== 32'd0 || issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b we=%b d=%h rdy=%b exp all 0", result_valid, result_we, result_data, issue_ready);
      end
      rst_ni = 1'b1;
      tick();
      checks++;
      if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", issue_ready); end
   endtask

   task automatic test_mac();
      run_op(3'd0, 32'd3, 32'd5, 32'd0, 0, 1'b0, 0);
      run_op(3'd0, 32'd2, 32'd4, 32'd0, 0, 1'b0, 0);
      checks++;
      if (acc_m !== 32'd23) begin errors++; $display("FAIL mac_model: got %h exp 00000017", acc_m); end
   endtask

   task automatic test_madd();
      run_op(3'd3, 32'hFFFFFFFF, 32'd2, 32'd5, 0, 1'b0, 0);
      run_op(3'd2, 32'd0, 32'd0, 32'd0, 0, 1'b0, 0);
   endtask

   task automatic test_kill();
      run_op(3'd0, 32'd100, 32'd100, 32'd0, 2, 1'b1, 0);
      run_op(3'd2, 32'd0, 32'd0, 32'd0, 0, 1'b0, 0);
      run_op(3'd2, 32'd0, 32'd0, 32'd0, 3, 1'b0, 0);
   endtask

   task automatic test_reject();
      rs_valid = 3'b000;
      instr = {25'd0, 7'h33};
      issue_valid = 1'b1;
      #1;
      checks++;
      if (accept !== 1'b0 || issue_ready !== 1'b1 || wb !== 1'b0 || reads !== 3'b000) begin
         errors++;
         $display("FAIL reject_op: got acc=%b rdy=%b wb=%b rd=%b exp 0 1 0 0", accept, issue_ready, wb, reads);
      end
      tick();
      issue_valid = 1'b0;
      tick();
      checks++;
      if (issue_ready !== 1'b1 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reject_idle: got rdy=%b v=%b exp 1 0", issue_ready, result_valid);
      end
      instr = enc(3'd7);
      #1;
      checks++;
      if (accept !== 1'b0 || issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL reject_f3: got acc=%b rdy=%b exp 0 1", accept, issue_ready);
      end
      instr = enc(3'd0); rs_valid = 3'b001;
      #1;
      checks++;
      if (issue_ready !== 1'b0) begin errors++; $display("FAIL gate_mac: got %b exp 0", issue_ready); end
      instr = enc(3'd3); rs_valid = 3'b011;
      #1;
      checks++;
      if (issue_ready !== 1'b0) begin errors++; $display("FAIL gate_madd: got %b exp 0", issue_ready); end
      instr = enc(3'd2); rs_valid = 3'b000;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin errors++; $display("FAIL gate_rdacc: got %b exp 1", issue_ready); end
   endtask

   task automatic test_backpressure();
      result_ready = 1'b0;
      run_op(3'd0, 32'h12345678, 32'h9ABCDEF1, 32'd0, 1, 1'b0, 10);
      result_ready = 1'b0;
      run_op(3'd1, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_op(3'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 0);
      end
   endtask

   task automatic test_reset_mid();
      run_op(3'd0, 32'd7, 32'd9, 32'd0, 0, 1'b0, 0);
      rs_valid = 3'b111;
      instr = enc(3'd0); rs1 = 32'd11; rs2 = 32'd13; rs3 = 32'd0;
      issue_valid = 1'b1; commit_valid = 1'b1; commit_kill = 1'b0;
      tick();
      issue_valid = 1'b0; commit_valid = 1'b0;
      repeat (5) tick();
      rst_ni = 1'b0;
      #1;
      checks++;
      if (result_valid !== 1'b0 || result_we !== 1'b0 || result_data !== 32'd0 || issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b we=%b d=%h rdy=%b exp all 0", result_valid, result_we, result_data, issue_ready);
      end
      acc_m = 32'd0;
      tick();
      rst_ni = 1'b1;
      tick();
      run_op(3'd2, 32'd0, 32'd0, 32'd0, 0, 1'b0, 0);
   endtask

   initial begin
      rst_ni = 1'b0; issue_valid = 1'b0; instr = 32'd0;
      rs1 = 32'd0; rs2 = 32'd0; rs3 = 32'd0; rs_valid = 3'b000;
      commit_valid = 1'b0; commit_kill = 1'b0; result_ready = 1'b1;
      repeat (3) tick();
      test_reset();
      test_mac();
      test_madd();
      test_kill();
      test_reject();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
